// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: CEA-861 1280x720p60 timing constants, FSM encodings and the output bundle.
package vid_timing_pkg;

   localparam int VID_H_ACTIVE = 1280;
   localparam int VID_H_FP     = 110;
   localparam int VID_H_SYNC   = 40;
   localparam int VID_H_BP     = 220;
   localparam int VID_H_TOTAL  = VID_H_ACTIVE + VID_H_FP + VID_H_SYNC + VID_H_BP;
   localparam int VID_HS_START = VID_H_ACTIVE + VID_H_FP;
   localparam int VID_HS_END   = VID_HS_START + VID_H_SYNC;

   localparam int VID_V_ACTIVE = 720;
   localparam int VID_V_FP     = 5;
   localparam int VID_V_SYNC   = 5;
   localparam int VID_V_BP     = 20;
   localparam int VID_V_TOTAL  = VID_V_ACTIVE + VID_V_FP + VID_V_SYNC + VID_V_BP;
   localparam int VID_VS_START = VID_V_ACTIVE + VID_V_FP;
   localparam int VID_VS_END   = VID_VS_START + VID_V_SYNC;

   localparam int VID_LOCK_QUAL_CYCLES = 1024;

   typedef logic [1:0] vid_state_t;
   localparam vid_state_t ST_WAIT_LOCK = 2'd0;
   localparam vid_state_t ST_QUALIFY   = 2'd1;
   localparam vid_state_t ST_RUN       = 2'd2;

   typedef struct packed {
      logic        hsync;
      logic        vsync;
      logic        hblank;
      logic        vblank;
      logic        de;
      logic        frame_start;
      logic        running;
      logic [10:0] x;
      logic [9:0]  y;
   } vid_out_t;

   localparam vid_out_t VID_OUT_IDLE = '{hsync: 1'b0, vsync: 1'b0, hblank: 1'b1, vblank: 1'b1,
                                         de: 1'b0, frame_start: 1'b0, running: 1'b0,
                                         x: 11'd0, y: 10'd0};

   // Half-open interval test [lo, hi) on counter values.
   function automatic logic in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vid_lock_qual.sv
// vid_lock_qual: 2-flop synchronizer for PLL lock plus consecutive-lock qualification counter.
// The counter exists only when VID_LOCK_QUAL_EN is defined; otherwise lock_ok follows lock_s.
module vid_lock_qual #(
   parameter int LOCK_QUAL_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   input  logic qual_clr,
   output logic lock_ok,
   output logic lock_lost
);

   logic [1:0] sync_q;
   logic       lock_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   assign lock_s    = sync_q[1];
   assign lock_lost = !lock_s;

`ifdef VID_LOCK_QUAL_EN
   localparam int QW = $clog2(LOCK_QUAL_CYCLES) + 1;
   localparam logic [QW-1:0] Q_LAST = QW'(LOCK_QUAL_CYCLES - 1);

   logic [QW-1:0] qual_cnt;

   // Any dropout restarts the count; it parks at Q_LAST once qualified.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qual_cnt <= '0;
      end else if (qual_clr || !lock_s) begin
         qual_cnt <= '0;
      end else if (qual_cnt != Q_LAST) begin
         qual_cnt <= qual_cnt + QW'(1);
      end
   end

   assign lock_ok = lock_s && (qual_cnt == Q_LAST);
`else
   logic unused_qual;
   assign unused_qual = qual_clr ^ LOCK_QUAL_CYCLES[0];
   assign lock_ok     = lock_s;
`endif

endmodule

// File: rtl/vid_timing_720p.sv
// vid_timing_720p: 720p60 raster generator started by a qualified PLL lock, blanked on lock loss.
// Define VID_LOCK_QUAL_EN to require LOCK_QUAL_CYCLES of stable lock before the raster runs.
module vid_timing_720p
   import vid_timing_pkg::*;
#(
   parameter int H_ACTIVE         = VID_H_ACTIVE,
   parameter int H_FP             = VID_H_FP,
   parameter int H_SYNC           = VID_H_SYNC,
   parameter int H_BP             = VID_H_BP,
   parameter int V_ACTIVE         = VID_V_ACTIVE,
   parameter int V_FP             = VID_V_FP,
   parameter int V_SYNC           = VID_V_SYNC,
   parameter int V_BP             = VID_V_BP,
   parameter int LOCK_QUAL_CYCLES = VID_LOCK_QUAL_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pll_locked,
   output logic        hsync,
   output logic        vsync,
   output logic        hblank,
   output logic        vblank,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        frame_start,
   output logic        running
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

`ifdef VID_LOCK_QUAL_EN
   localparam vid_state_t ST_AFTER_LOCK = ST_QUALIFY;
`else
   localparam vid_state_t ST_AFTER_LOCK = ST_RUN;
`endif

   vid_state_t  state_q, state_d;
   vid_out_t    out_q, out_d;
   logic [10:0] h_d;
   logic [9:0]  v_d;
   logic        run_d;
   logic        qual_clr, lock_ok, lock_lost;

   assign qual_clr = (state_q == ST_WAIT_LOCK);

   vid_lock_qual #(
      .LOCK_QUAL_CYCLES(LOCK_QUAL_CYCLES)
   ) u_lock_qual (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .qual_clr  (qual_clr),
      .lock_ok   (lock_ok),
      .lock_lost (lock_lost)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT_LOCK: if (!lock_lost) state_d = ST_AFTER_LOCK;
         ST_QUALIFY: begin
            if (lock_lost)    state_d = ST_WAIT_LOCK;
            else if (lock_ok) state_d = ST_RUN;
         end
         ST_RUN:       if (lock_lost) state_d = ST_WAIT_LOCK;
         default:      state_d = ST_WAIT_LOCK;
      endcase
   end

   assign run_d = (state_d == ST_RUN);

   // Counters live in the output register; entering RUN starts at (0,0).
   always_comb begin
      h_d = '0;
      v_d = '0;
      if (state_q == ST_RUN && run_d) begin
         h_d = out_q.x + 11'd1;
         v_d = out_q.y;
         if (out_q.x == H_LAST) begin
            h_d = '0;
            v_d = (out_q.y == V_LAST) ? 10'd0 : out_q.y + 10'd1;
         end
      end
   end

   // Decode the next counter values so every output lands on the same edge.
   always_comb begin
      out_d = VID_OUT_IDLE;
      if (run_d) begin
         out_d.running     = 1'b1;
         out_d.x           = h_d;
         out_d.y           = v_d;
         out_d.hblank      = !in_range(int'(h_d), 0, H_ACTIVE);
         out_d.vblank      = !in_range(int'(v_d), 0, V_ACTIVE);
         out_d.hsync       = in_range(int'(h_d), HS_START, HS_END);
         out_d.vsync       = in_range(int'(v_d), VS_START, VS_END);
         out_d.de          = !out_d.hblank && !out_d.vblank;
         out_d.frame_start = (h_d == 11'd0) && (v_d == 10'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT_LOCK;
         out_q   <= VID_OUT_IDLE;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign hsync       = out_q.hsync;
   assign vsync       = out_q.vsync;
   assign hblank      = out_q.hblank;
   assign vblank      = out_q.vblank;
   assign de          = out_q.de;
   assign x           = out_q.x;
   assign y           = out_q.y;
   assign frame_start = out_q.frame_start;
   assign running     = out_q.running;

endmodule
